rx_char_queue: RTL and testbench

Character queue between the UART receiver and the Morse keyer. Accepts one received byte per strobe and normalises it: folds lower case to upper case, maps CR/LF to space, discards unusable bytes. Buffers normalised 7-bit ASCII in a circular store. Presents the oldest entry to the keyer on a valid/ready handshake, so the keyer pops a character only when it starts a new letter.

---
 rtl/rx_char_queue.sv | 114 +++++++++++
 tb/tb_rx_char_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_char_queue.sv
// Normalising receive-character queue (UART -> Morse keyer); RXQ_BACKSPACE_EN enables 0x08/0x7F erase.
// Latency: a byte strobed on cycle N is presented first-word-fall-through on cycle N+1.
// Backpressure: out_valid/out_ready pop; a push into a full queue without a pop is lost and flagged.
module rx_char_queue #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk_24,
    input  logic                  rst,
    input  logic                  rx_stb,
    input  logic [7:0]            rx_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [6:0]            out_ascii,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  overflow,
    output logic [7:0]            drop_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_TWO  = (DEPTH_LOG2+1)'(2);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

    logic [6:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   level_nxt;

    logic       char_ok;
    logic [6:0] char_val;
    logic       bs_req;
    logic       filtered;
    logic       pop;
    logic       push;
    logic       lost;
    logic       bs_do;

    always_comb begin
        char_ok  = 1'b0;
        char_val = '0;
        bs_req   = 1'b0;
        if (!rx_data[7]) begin
            if (rx_data >= 8'h61 && rx_data <= 8'h7A) begin
                char_ok  = 1'b1;
                char_val = rx_data[6:0] - 7'h20;
            end else if (rx_data == 8'h0D || rx_data == 8'h0A) begin
                char_ok  = 1'b1;
                char_val = 7'h20;
            end else if (rx_data >= 8'h20 && rx_data != 8'h7F) begin
                char_ok  = 1'b1;
                char_val = rx_data[6:0];
            end
`ifdef RXQ_BACKSPACE_EN
            else if (rx_data == 8'h08 || rx_data == 8'h7F) begin
                bs_req = 1'b1;
            end
`endif
        end
    end

    // Backspace on a queue that is (or is about to be) empty is silently ignored, not counted.
    always_comb begin
        pop       = out_valid && out_ready;
        filtered  = rx_stb && !char_ok && !bs_req;
        push      = rx_stb && char_ok && (!full || pop);
        lost      = rx_stb && char_ok && full && !pop;
        bs_do     = rx_stb && bs_req && ((level >= LVL_TWO) || (level == LVL_ONE && !pop));
        level_nxt = level + (DEPTH_LOG2+1)'(push)
                          - (DEPTH_LOG2+1)'(pop)
                          - (DEPTH_LOG2+1)'(bs_do);
    end

    always_ff @(posedge clk_24) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            out_valid  <= 1'b0;
            full       <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end else if (bs_do) begin
                wr_ptr <= wr_ptr - PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
            full      <= (level_nxt == LVL_FULL);
            if (lost) begin
                overflow <= 1'b1;
            end
            if ((filtered || lost) && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    // Storage carries no reset; pointers and level define what is valid.
    always_ff @(posedge clk_24) begin
        if (push) begin
            mem[wr_ptr] <= char_val;
        end
    end

    assign out_ascii = out_valid ? mem[rd_ptr] : 7'h00;

endmodule

// File: tb/tb_rx_char_queue.sv
// Bench for rx_char_queue: directed scenarios plus a randomized run against a queue-based model.
module tb_rx_char_queue;

    localparam int DL = 6;
    localparam int CAP = 1 << DL;

    logic          clk_24 = 1'b0;
    logic          rst;
    logic          rx_stb;
    logic [7:0]    rx_data;
    logic          out_valid;
    logic          out_ready;
    logic [6:0]    out_ascii;
    logic [DL:0]   level;
    logic          full;
    logic          overflow;
    logic [7:0]    drop_count;

    int errors = 0;
    int checks = 0;

    logic [6:0] mq[$];
    bit         m_ovf;
    int         m_drop;

    rx_char_queue #(.DEPTH_LOG2(DL)) dut (
        .clk_24(clk_24), .rst(rst), .rx_stb(rx_stb), .rx_data(rx_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ascii(out_ascii),
        .level(level), .full(full), .overflow(overflow), .drop_count(drop_count)
    );

    initial forever #5 clk_24 = ~clk_24;

    task automatic do_reset(input logic stb, input logic [7:0] d);
        rst = 1'b1; rx_stb = stb; rx_data = d; out_ready = 1'b0;
        @(posedge clk_24);
        @(negedge clk_24);
        rst = 1'b0; rx_stb = 1'b0;
        mq.delete(); m_ovf = 0; m_drop = 0;
    endtask

    // One clock of stimulus; the model follows the character rules directly.
    task automatic step(input logic stb, input logic [7:0] d, input logic rdy);
        bit has_ch, bs, drop, pop;
        logic [6:0] ch;
        int n;
        rx_stb = stb; rx_data = d; out_ready = rdy;
        n = mq.size();
        pop = rdy && (n > 0);
        has_ch = 0; bs = 0; drop = 0; ch = 7'h00;
        if (stb) begin
            if (d >= 8'h80) drop = 1;
            else if (d >= 8'h61 && d <= 8'h7A) begin has_ch = 1; ch = 7'(d - 8'h20); end
            else if (d == 8'h0D || d == 8'h0A) begin has_ch = 1; ch = 7'h20; end
            else if (d >= 8'h20 && d <= 8'h7E) begin has_ch = 1; ch = d[6:0]; end
`ifdef RXQ_BACKSPACE_EN
            else if (d == 8'h08 || d == 8'h7F) bs = 1;
`endif
            else drop = 1;
        end
        @(posedge clk_24);
        if (pop) void'(mq.pop_front());
        if (has_ch) begin
            if (n == CAP && !pop) begin m_ovf = 1; drop = 1; end
            else mq.push_back(ch);
        end
        if (bs && (n >= 2 || (n == 1 && !pop))) void'(mq.pop_back());
        if (drop && m_drop < 255) m_drop++;
        @(negedge clk_24);
        rx_stb = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(1'b0, 8'h00);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (level !== 7'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags full=%b ovf=%b want 0 0", full, overflow); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count); end
        checks++; if (out_ascii !== 7'h00) begin errors++; $display("FAIL reset_ascii got %h want 00", out_ascii); end
    endtask

    task automatic test_basic;
        step(1'b1, 8'h61, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_ascii !== 7'h41) begin errors++; $display("FAIL basic_head valid=%b ascii=%h want 1 41", out_valid, out_ascii); end
        checks++; if (level !== 7'd1) begin errors++; $display("FAIL basic_level got %0d want 1", level); end
        step(1'b0, 8'h00, 1'b1);
        checks++; if (out_valid !== 1'b0 || level !== 7'd0) begin errors++; $display("FAIL basic_pop valid=%b level=%0d want 0 0", out_valid, level); end
        step(1'b0, 8'h00, 1'b1);
        checks++; if (out_valid !== 1'b0 || level !== 7'd0) begin errors++; $display("FAIL basic_idle_pop valid=%b level=%0d want 0 0", out_valid, level); end
    endtask

    task automatic test_filter;
        do_reset(1'b0, 8'h00);
        step(1'b1, 8'h0D, 1'b0);
        step(1'b1, 8'h09, 1'b0);
        step(1'b1, 8'hC1, 1'b0);
        step(1'b1, 8'h7B, 1'b0);
        checks++; if (level !== 7'd2 || drop_count !== 8'd2) begin errors++; $display("FAIL filter_counts level=%0d drop=%0d want 2 2", level, drop_count); end
        checks++; if (out_ascii !== 7'h20) begin errors++; $display("FAIL filter_cr got %h want 20", out_ascii); end
        step(1'b0, 8'h00, 1'b1);
        checks++; if (out_ascii !== 7'h7B) begin errors++; $display("FAIL filter_brace got %h want 7b", out_ascii); end
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_full_wrap;
        logic [7:0] e;
        do_reset(1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h30, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < CAP; i++) begin
            e = 8'(8'h41 + i % 32);
            step(1'b1, e, 1'b0);
        end
        checks++; if (full !== 1'b1 || level !== 7'd64) begin errors++; $display("FAIL fill full=%b level=%0d want 1 64", full, level); end
        checks++; if (out_ascii !== 7'h41 || overflow !== 1'b0) begin errors++; $display("FAIL fill_head ascii=%h ovf=%b want 41 0", out_ascii, overflow); end
        step(1'b1, 8'h42, 1'b0);
        checks++; if (overflow !== 1'b1 || drop_count !== 8'd1 || level !== 7'd64) begin errors++; $display("FAIL overflow ovf=%b drop=%0d level=%0d want 1 1 64", overflow, drop_count, level); end
        step(1'b1, 8'h5A, 1'b1);
        checks++; if (level !== 7'd64 || full !== 1'b1) begin errors++; $display("FAIL full_pushpop level=%0d full=%b want 64 1", level, full); end
        for (int k = 0; k < CAP; k++) begin
            e = (k < CAP - 1) ? 8'(8'h41 + (k + 1) % 32) : 8'h5A;
            checks++;
            if (out_valid !== 1'b1 || out_ascii !== e[6:0]) begin
                errors++; $display("FAIL drain_%0d valid=%b ascii=%h want 1 %h", k, out_valid, out_ascii, e[6:0]);
            end
            step(1'b0, 8'h00, 1'b1);
        end
        checks++; if (out_valid !== 1'b0 || level !== 7'd0 || full !== 1'b0) begin errors++; $display("FAIL drained valid=%b level=%0d full=%b want 0 0 0", out_valid, level, full); end
    endtask

    task automatic test_backspace;
        do_reset(1'b0, 8'h00);
        step(1'b1, 8'h48, 1'b0);
        step(1'b1, 8'h49, 1'b0);
        step(1'b1, 8'h08, 1'b0);
`ifdef RXQ_BACKSPACE_EN
        checks++; if (level !== 7'd1 || out_ascii !== 7'h48 || drop_count !== 8'd0) begin errors++; $display("FAIL bs_erase level=%0d ascii=%h drop=%0d want 1 48 0", level, out_ascii, drop_count); end
        step(1'b0, 8'h00, 1'b1);
        checks++; if (level !== 7'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bs_drain level=%0d valid=%b want 0 0", level, out_valid); end
        step(1'b1, 8'h7F, 1'b0);
        checks++; if (level !== 7'd0 || drop_count !== 8'd0) begin errors++; $display("FAIL bs_empty level=%0d drop=%0d want 0 0", level, drop_count); end
`else
        checks++; if (level !== 7'd2 || out_ascii !== 7'h48 || drop_count !== 8'd1) begin errors++; $display("FAIL bs_off level=%0d ascii=%h drop=%0d want 2 48 1", level, out_ascii, drop_count); end
        step(1'b1, 8'h7F, 1'b0);
        checks++; if (level !== 7'd2 || drop_count !== 8'd2) begin errors++; $display("FAIL del_off level=%0d drop=%0d want 2 2", level, drop_count); end
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
`endif
    endtask

    task automatic test_reset_mid;
        do_reset(1'b0, 8'h00);
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
        step(1'b1, 8'h01, 1'b0);
        checks++; if (level !== 7'd10 || drop_count !== 8'd1) begin errors++; $display("FAIL pre_reset level=%0d drop=%0d want 10 1", level, drop_count); end
        do_reset(1'b1, 8'h41);
        checks++; if (level !== 7'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
            errors++; $display("FAIL mid_reset level=%0d valid=%b ovf=%b drop=%0d want 0 0 0 0", level, out_valid, overflow, drop_count);
        end
        for (int i = 0; i < 300; i++) step(1'b1, 8'h01, 1'b0);
        checks++; if (drop_count !== 8'd255 || level !== 7'd0) begin errors++; $display("FAIL drop_sat drop=%0d level=%0d want 255 0", drop_count, level); end
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic stb, rdy;
        int r;
        do_reset(1'b0, 8'h00);
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4, 5: d = 8'($urandom_range(32, 126));
                6: d = 8'($urandom_range(0, 255));
                7: d = 8'($urandom_range(97, 122));
                8: d = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
                default: d = ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F;
            endcase
            stb = ($urandom_range(0, 9) < 6);
            rdy = ((c / 250) % 2 == 1) ? ($urandom_range(0, 9) < 1) : ($urandom_range(0, 9) < 8);
            step(stb, d, rdy);
            checks++; if (level !== 7'(mq.size())) begin errors++; $display("FAIL rnd_level c=%0d got %0d want %0d", c, level, mq.size()); end
            checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid c=%0d got %b want %b", c, out_valid, mq.size() > 0); end
            checks++; if (full !== (mq.size() == CAP)) begin errors++; $display("FAIL rnd_full c=%0d got %b want %b", c, full, mq.size() == CAP); end
            checks++; if (overflow !== m_ovf || drop_count !== 8'(m_drop)) begin errors++; $display("FAIL rnd_flags c=%0d ovf=%b drop=%0d want %b %0d", c, overflow, drop_count, m_ovf, m_drop); end
            if (mq.size() > 0) begin
                checks++; if (out_ascii !== mq[0]) begin errors++; $display("FAIL rnd_head c=%0d got %h want %h", c, out_ascii, mq[0]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; rx_stb = 1'b0; rx_data = 8'h00; out_ready = 1'b0;
        test_reset;
        test_basic;
        test_filter;
        test_full_wrap;
        test_backspace;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
